data_cache_controller: RTL and testbench

//  Responder for the MEM-stage memory requests issued from the EX/MEM pipeline register.

---
 rtl/cpu_mem_pkg.sv | 25 ++
 rtl/dcache_lane_select.sv | 47 ++++
 rtl/data_cache_controller.sv | 144 ++++++++++++++
 tb/tb_data_cache_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared MEM-stage definitions: load/store op encodings, data-cache FSM states and line geometry.
package cpu_mem_pkg;

    localparam int WORD_BITS   = 32;
    localparam int LINE_BITS   = 128;
    localparam int OFFSET_BITS = 4;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LB   = 3'b001;
    localparam logic [2:0] LD_LH   = 3'b010;
    localparam logic [2:0] LD_LW   = 3'b011;
    localparam logic [2:0] LD_LBU  = 3'b100;
    localparam logic [2:0] LD_LHU  = 3'b101;

    localparam logic [2:0] ST_NONE = 3'b000;
    localparam logic [2:0] ST_SB   = 3'b001;
    localparam logic [2:0] ST_SH   = 3'b010;
    localparam logic [2:0] ST_SW   = 3'b011;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_FETCH     = 2'd2;
    localparam logic [1:0] S_FILL      = 2'd3;

endpackage

// File: rtl/dcache_lane_select.sv
// Combinational byte-lane logic for one 128-bit cache line: load extraction with
// sign/zero extension, and store byte-merge.
module dcache_lane_select
    import cpu_mem_pkg::*;
(
    input  logic [LINE_BITS-1:0]   line,
    input  logic [OFFSET_BITS-1:0] offset,
    input  logic [2:0]             load_op,
    input  logic [2:0]             store_op,
    input  logic [WORD_BITS-1:0]   wdata,
    output logic [WORD_BITS-1:0]   rdata,
    output logic [LINE_BITS-1:0]   merged_line
);

    logic [WORD_BITS-1:0] word;
    logic [15:0]          half;
    logic [7:0]           byte_val;

    // Halfword lanes ignore offset[0]; word lanes ignore offset[1:0].
    assign word     = line[{offset[3:2], 5'b0} +: 32];
    assign half     = word[{offset[1], 4'b0} +: 16];
    assign byte_val = word[{offset[1:0], 3'b0} +: 8];

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rdata = '0;
        case (load_op)
            LD_LB:   rdata = {{24{byte_val[7]}}, byte_val};
            LD_LH:   rdata = {{16{half[15]}}, half};
            LD_LW:   rdata = word;
            LD_LBU:  rdata = {24'b0, byte_val};
            LD_LHU:  rdata = {16'b0, half};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        merged_line = line;
        case (store_op)
            ST_SB:   merged_line[{offset, 3'b0} +: 8]        = wdata[7:0];
            ST_SH:   merged_line[{offset[3:1], 4'b0} +: 16]  = wdata[15:0];
            ST_SW:   merged_line[{offset[3:2], 5'b0} +: 32]  = wdata;
            default: merged_line = line;
        endcase
    end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Define DCACHE_STATS_EN to add HIT_COUNT/MISS_COUNT statistics outputs.
module data_cache_controller
    import cpu_mem_pkg::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [2:0]             MEM_READ,
    input  logic [2:0]             MEM_WRITE,
    input  logic [31:0]            ADDRESS,
    input  logic [WORD_BITS-1:0]   WRITE_DATA,
    output logic [WORD_BITS-1:0]   READ_DATA,
    output logic                   BUSY_WAIT,
    output logic                   MAIN_READ,
    output logic                   MAIN_WRITE,
    output logic [27:0]            MAIN_ADDRESS,
    output logic [LINE_BITS-1:0]   MAIN_WRITEDATA,
    input  logic [LINE_BITS-1:0]   MAIN_READDATA,
`ifdef DCACHE_STATS_EN
    output logic [31:0]            HIT_COUNT,
    output logic [31:0]            MISS_COUNT,
    input  logic                   MAIN_BUSYWAIT
`else
    input  logic                   MAIN_BUSYWAIT
`endif
);

    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS = 32 - OFFSET_BITS - IDX_BITS;

    logic [LINE_BITS-1:0] data_mem [NUM_SETS];
    logic [TAG_BITS-1:0]  tag_mem  [NUM_SETS];
    logic [NUM_SETS-1:0]  valid;
    logic [NUM_SETS-1:0]  dirty;

    logic [1:0]           state;
    logic [1:0]           next_state;
    logic [IDX_BITS-1:0]  idx;
    logic [TAG_BITS-1:0]  addr_tag;
    logic                 is_load;
    logic                 is_store;
    logic                 request;
    logic                 hit;
    logic                 idle_hit;
    logic                 store_hit;
    logic [2:0]           store_op;
    logic [WORD_BITS-1:0] lane_rdata;
    logic [LINE_BITS-1:0] merged_line;

    assign idx      = ADDRESS[OFFSET_BITS +: IDX_BITS];
    assign addr_tag = ADDRESS[31 -: TAG_BITS];

    // A simultaneous load and store is served as the load; the store is dropped.
    assign is_load   = (MEM_READ != LD_NONE);
    assign is_store  = !is_load && (MEM_WRITE != ST_NONE);
    assign request   = is_load || (MEM_WRITE != ST_NONE);
    assign store_op  = is_store ? MEM_WRITE : ST_NONE;

    assign hit       = valid[idx] && (tag_mem[idx] == addr_tag);
    assign idle_hit  = (state == S_IDLE) && hit;
    assign store_hit = idle_hit && is_store;

    dcache_lane_select u_lane_select (
        .line        (data_mem[idx]),
        .offset      (ADDRESS[OFFSET_BITS-1:0]),
        .load_op     (MEM_READ),
        .store_op    (store_op),
        .wdata       (WRITE_DATA),
        .rdata       (lane_rdata),
        .merged_line (merged_line)
    );

    assign BUSY_WAIT      = request && !idle_hit;
    assign READ_DATA      = (idle_hit && is_load) ? lane_rdata : '0;
    assign MAIN_WRITE     = (state == S_WRITEBACK);
    assign MAIN_READ      = (state == S_FETCH);
    assign MAIN_ADDRESS   = (state == S_WRITEBACK) ? {tag_mem[idx], idx} : ADDRESS[31:4];
    assign MAIN_WRITEDATA = data_mem[idx];

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (request && !hit)
                             next_state = (valid[idx] && dirty[idx]) ? S_WRITEBACK : S_FETCH;
            S_WRITEBACK: if (!MAIN_BUSYWAIT) next_state = S_FETCH;
            S_FETCH:     if (!MAIN_BUSYWAIT) next_state = S_FILL;
            S_FILL:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, whatever the block order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= next_state;
            if (state == S_FILL) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end else if (store_hit) begin
                dirty[idx] <= 1'b1;
            end
        end
    end

    // NOTE: line data and tags carry no reset; clearing valid is enough and keeps the arrays mappable to plain RAM.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state == S_FILL) begin
                data_mem[idx] <= MAIN_READDATA;
                tag_mem[idx]  <= addr_tag;
            end else if (store_hit) begin
                data_mem[idx] <= merged_line;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // The access that completes right after a refill was already counted as a miss.
    logic refilled;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            refilled   <= 1'b0;
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            refilled <= (state == S_FILL);
            if ((state == S_IDLE) && request) begin
                if (!hit)
                    MISS_COUNT <= MISS_COUNT + 32'd1;
                else if (!refilled)
                    HIT_COUNT <= HIT_COUNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache_controller.sv
// Scoreboard bench for data_cache_controller: directed CPU ops push expected results,
// a negedge monitor pops and compares on CPU and main-memory completions.
module tb_data_cache_controller;
    import cpu_mem_pkg::*;

    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   mem_read;
    logic [2:0]   mem_write;
    logic [31:0]  address;
    logic [31:0]  write_data;
    logic [31:0]  read_data;
    logic         busy_wait;
    logic         main_read;
    logic         main_write;
    logic [27:0]  main_address;
    logic [127:0] main_writedata;
    logic [127:0] main_readdata;
    logic         main_busywait;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    data_cache_controller dut (
        .CLK            (clk),
        .RESET          (reset),
        .MEM_READ       (mem_read),
        .MEM_WRITE      (mem_write),
        .ADDRESS        (address),
        .WRITE_DATA     (write_data),
        .READ_DATA      (read_data),
        .BUSY_WAIT      (busy_wait),
        .MAIN_READ      (main_read),
        .MAIN_WRITE     (main_write),
        .MAIN_ADDRESS   (main_address),
        .MAIN_WRITEDATA (main_writedata),
        .MAIN_READDATA  (main_readdata),
`ifdef DCACHE_STATS_EN
        .HIT_COUNT      (hit_count),
        .MISS_COUNT     (miss_count),
`endif
        .MAIN_BUSYWAIT  (main_busywait)
    );

    always #5 clk = ~clk;

    // Main memory: read-only contents; a request completes on its third cycle.
    function automatic logic [127:0] mem_line(input logic [27:0] a);
        case (a)
            28'h0000000: return {32'h0F0F0F0F, 32'h0E0E0E0E, 32'h0D0D0D0D, 32'h01234567};
            28'h0000004: return {32'h44444444, 32'h33333333, 32'h22222222, 32'hDEADBEEF};
            28'h0000014: return {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
            28'h0000020: return {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
            default:     return {4{32'h5A5A5A5A}};
        endcase
    endfunction

    logic [1:0] mem_cnt;
    logic       mem_req;

    assign mem_req       = main_read | main_write;
    assign main_busywait = mem_req && (mem_cnt != 2'(LAT));
    always_comb main_readdata = mem_line(main_address);

    always @(posedge clk) begin
        if (reset || !mem_req || mem_cnt == 2'(LAT))
            mem_cnt <= 2'd0;
        else
            mem_cnt <= mem_cnt + 2'd1;
    end

    typedef struct {
        logic        is_load;
        logic [31:0] data;
        string       name;
    } cpu_exp_t;

    typedef struct {
        logic         is_write;
        logic [27:0]  addr;
        logic [127:0] data;
        string        name;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];
    cpu_exp_t ce;
    mem_exp_t me;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: compares whenever the CPU side or the memory side completes.
    always @(negedge clk) begin
        if (!reset) begin
            if ((mem_read != 3'b0 || mem_write != 3'b0) && !busy_wait) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_unexpected_completion", 128'(1), 128'(0));
                end else begin
                    ce = cpu_q.pop_front();
                    if (ce.is_load)
                        check(ce.name, 128'(read_data), 128'(ce.data));
                end
            end
            if (mem_req && !main_busywait) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_request", 128'(1), 128'(0));
                end else begin
                    me = mem_q.pop_front();
                    check({me.name, "_kind"}, 128'({main_write, main_read}),
                          128'({me.is_write, !me.is_write}));
                    check({me.name, "_addr"}, 128'(main_address), 128'(me.addr));
                    if (me.is_write)
                        check({me.name, "_data"}, main_writedata, me.data);
                end
            end
        end
    end

    task automatic expect_mem(input logic is_write, input logic [27:0] addr,
                              input logic [127:0] data, input string name);
        mem_exp_t e;
        e.is_write = is_write;
        e.addr     = addr;
        e.data     = data;
        e.name     = name;
        mem_q.push_back(e);
    endtask

    // Issue one CPU access, hold it while stalled, and check the stall length.
    task automatic op(input logic [2:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_data,
                      input int exp_busy, input string name);
        cpu_exp_t e;
        int       busy;
        e.is_load = (rd != 3'b0);
        e.data    = exp_data;
        e.name    = name;
        cpu_q.push_back(e);
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = wd;
        busy = 0;
        @(negedge clk);
        while (busy_wait && busy < 100) begin
            busy++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 128'(busy), 128'(exp_busy));
        @(posedge clk);
        #1;
        mem_read  = 3'b0;
        mem_write = 3'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        mem_read = 3'b0;
        mem_write = 3'b0;
        address = 32'h0;
        write_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_read_data", 128'(read_data), 128'(0));
        check("rst_busy_wait", 128'(busy_wait), 128'(0));
        check("rst_main_read", 128'(main_read), 128'(0));
        check("rst_main_write", 128'(main_write), 128'(0));
`ifdef DCACHE_STATS_EN
        check("rst_hit_count", 128'(hit_count), 128'(0));
        check("rst_miss_count", 128'(miss_count), 128'(0));
`endif

        // 1: cold miss, clean fetch: 1 IDLE + 3 FETCH + 1 FILL stalled cycles.
        expect_mem(1'b0, 28'h0000004, '0, "t1_fetch");
        op(LD_LW, ST_NONE, 32'h40, 32'h0, 32'hDEADBEEF, 5, "t1_lw_40");

        // 2: hits on line 0x40; word0 becomes DEAD80EF, word1 becomes 12345678.
        op(LD_NONE, ST_SB, 32'h41, 32'hFFFFFF80, 32'h0, 0, "t2_sb_41");
        op(LD_LB,   ST_NONE, 32'h41, 32'h0, 32'hFFFFFF80, 0, "t2_lb_41");
        op(LD_LBU,  ST_NONE, 32'h41, 32'h0, 32'h00000080, 0, "t2_lbu_41");
        op(LD_LH,   ST_NONE, 32'h42, 32'h0, 32'hFFFFDEAD, 0, "t2_lh_42");
        op(LD_LH,   ST_NONE, 32'h43, 32'h0, 32'hFFFFDEAD, 0, "t2_lh_43");
        op(LD_LW,   ST_NONE, 32'h4C, 32'h0, 32'h44444444, 0, "t2_lw_4c");
        op(LD_LW,   ST_NONE, 32'h4F, 32'h0, 32'h44444444, 0, "t2_lw_4f");
        op(LD_NONE, ST_SW, 32'h44, 32'h12345678, 32'h0, 0, "t2_sw_44");
        op(LD_LW,   ST_NONE, 32'h44, 32'h0, 32'h12345678, 0, "t2_lw_44");

        // 3: conflict miss on a dirty line: writeback then fetch, 1 + 3 + 3 + 1 stalled cycles.
        expect_mem(1'b1, 28'h0000004,
                   {32'h44444444, 32'h33333333, 32'h12345678, 32'hDEAD80EF}, "t3_writeback");
        expect_mem(1'b0, 28'h0000014, '0, "t3_fetch");
        op(LD_LW, ST_NONE, 32'h140, 32'h0, 32'hA0A0A0A0, 8, "t3_lw_140");
`ifdef DCACHE_STATS_EN
        check("t6_hit_count", 128'(hit_count), 128'(9));
        check("t6_miss_count", 128'(miss_count), 128'(2));
`endif
        // Load and store together: load wins, line unchanged.
        op(LD_LW, ST_SW, 32'h144, 32'hCAFEF00D, 32'hA1A1A1A1, 0, "t3_lw_sw_144");
        op(LD_LW, ST_NONE, 32'h144, 32'h0, 32'hA1A1A1A1, 0, "t3_lw_144");

        // 4: store miss on a clean set allocates, then merges; word0 becomes BEEFC0C0.
        expect_mem(1'b0, 28'h0000020, '0, "t4_fetch");
        op(LD_NONE, ST_SH, 32'h202, 32'h1234BEEF, 32'h0, 5, "t4_sh_202");
        op(LD_LHU, ST_NONE, 32'h202, 32'h0, 32'h0000BEEF, 0, "t4_lhu_202");
        op(LD_LH,  ST_NONE, 32'h203, 32'h0, 32'hFFFFBEEF, 0, "t4_lh_203");
        op(LD_LB,  ST_NONE, 32'h203, 32'h0, 32'hFFFFFFBE, 0, "t4_lb_203");
        op(LD_LW,  ST_NONE, 32'h200, 32'h0, 32'hBEEFC0C0, 0, "t4_lw_200");
        // The allocated line is dirty: evicting it writes the merged data back.
        expect_mem(1'b1, 28'h0000020,
                   {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hBEEFC0C0}, "t4_writeback");
        expect_mem(1'b0, 28'h0000000, '0, "t4_fetch0");
        op(LD_LW, ST_NONE, 32'h002, 32'h0, 32'h01234567, 8, "t4_lw_002");

        // 5: reset while fetching drops the request and invalidates every line.
        mem_read = LD_LW;
        address  = 32'h300;
        n = 0;
        while (!main_read && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_fetch_reached", 128'(main_read), 128'(1));
        reset    = 1'b1;
        mem_read = 3'b0;
        @(posedge clk);
        #1;
        check("t5_main_read", 128'(main_read), 128'(0));
        check("t5_main_write", 128'(main_write), 128'(0));
        check("t5_busy_wait", 128'(busy_wait), 128'(0));
        reset = 1'b0;
        expect_mem(1'b0, 28'h0000014, '0, "t5_refetch_14");
        op(LD_LW, ST_NONE, 32'h144, 32'h0, 32'hA1A1A1A1, 5, "t5_lw_144");
        expect_mem(1'b0, 28'h0000030, '0, "t5_fetch_30");
        op(LD_LW, ST_NONE, 32'h300, 32'h0, 32'h5A5A5A5A, 5, "t5_lw_300");
`ifdef DCACHE_STATS_EN
        check("t6_hit_after_reset", 128'(hit_count), 128'(0));
        check("t6_miss_after_reset", 128'(miss_count), 128'(2));
`endif

        repeat (2) @(posedge clk);
        check("cpu_q_drained", 128'(cpu_q.size()), 128'(0));
        check("mem_q_drained", 128'(mem_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
